// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back in one clock.
// Instruction ROM, data RAM and the 32x32 register file live inside; debug ports expose the datapath.

module rv32i_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] Registers [0:31];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                Registers[i] <= 32'h0;
            end
        end else if (we && (waddr != 5'd0)) begin
            Registers[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : Registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : Registers[raddr2];
endmodule

module rv32i_single_cycle_core #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = "program.hex"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_instr,
    output logic [31:0] dbg_rs1_data,
    output logic [31:0] dbg_rs2_data,
    output logic [31:0] dbg_alu_out,
    output logic [31:0] dbg_wb_data,
    output logic        dbg_reg_we
);
    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];

    logic [31:0] pc, next_pc, pc_plus4, instr;
    logic [31:0] rs1_data, rs2_data, operand_b, alu_out, wb_data, load_data, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic        dec_we, use_imm, is_store, is_branch, branch_ne, is_jal;
    logic        rf_we, branch_taken, dmem_in_range;

    assign instr = (pc[31:2] < 30'(IMEM_DEPTH)) ? imem[pc[IMEM_AW+1:2]] : 32'h0;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Anything not matched below leaves every enable low and therefore behaves as a NOP.
    always_comb begin
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        dec_we    = 1'b0;
        use_imm   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        branch_ne = 1'b0;
        is_jal    = 1'b0;
        imm       = 32'h0;
        case (opcode)
            OPC_OP: begin
                dec_we = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         dec_we = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_we  = 1'b1;
                use_imm = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op = ALU_SLL;
                        dec_we = (funct7 == 7'h00);
                    end
                    default: begin
                        alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        dec_we = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_we  = (funct3 == 3'b010);
                use_imm = 1'b1;
                wb_sel  = WB_MEM;
                imm     = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                is_store = (funct3 == 3'b010);
                use_imm  = 1'b1;
                imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                is_branch = (funct3 == 3'b000) || (funct3 == 3'b001);
                branch_ne = funct3[0];
                imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                dec_we = 1'b1;
                wb_sel = WB_PC4;
                imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_LUI: begin
                dec_we = 1'b1;
                wb_sel = WB_IMM;
                imm    = {instr[31:12], 12'h0};
            end
            default: begin
                dec_we = 1'b0;
            end
        endcase
    end

    assign rf_we = dec_we && (rd != 5'd0);

    rv32i_regfile Reg_File (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign operand_b = use_imm ? imm : rs2_data;

    always_comb begin
        alu_out = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_out = rs1_data + operand_b;
            ALU_SUB:  alu_out = rs1_data - operand_b;
            ALU_SLL:  alu_out = rs1_data << operand_b[4:0];
            ALU_SLT:  alu_out = {31'h0, $signed(rs1_data) < $signed(operand_b)};
            ALU_SLTU: alu_out = {31'h0, rs1_data < operand_b};
            ALU_XOR:  alu_out = rs1_data ^ operand_b;
            ALU_SRL:  alu_out = rs1_data >> operand_b[4:0];
            ALU_SRA:  alu_out = $unsigned($signed(rs1_data) >>> operand_b[4:0]);
            ALU_OR:   alu_out = rs1_data | operand_b;
            ALU_AND:  alu_out = rs1_data & operand_b;
            default:  alu_out = 32'h0;
        endcase
    end

    // Word addressing only; out-of-range words read as zero and are never written.
    assign dmem_in_range = (alu_out[31:2] < 30'(DMEM_DEPTH));
    assign load_data     = dmem_in_range ? dmem[alu_out[DMEM_AW+1:2]] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset && is_store && dmem_in_range) begin
            dmem[alu_out[DMEM_AW+1:2]] <= rs2_data;
        end
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        wb_data = alu_out;
        case (wb_sel)
            WB_ALU: wb_data = alu_out;
            WB_MEM: wb_data = load_data;
            WB_PC4: wb_data = pc_plus4;
            WB_IMM: wb_data = imm;
            default: wb_data = alu_out;
        endcase
    end

    assign branch_taken = is_branch && ((rs1_data == rs2_data) != branch_ne);
    assign next_pc      = (is_jal || branch_taken) ? (pc + imm) : pc_plus4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= 32'h0;
        end else begin
            pc <= next_pc;
        end
    end

    assign dbg_pc       = pc;
    assign dbg_instr    = instr;
    assign dbg_rs1_data = rs1_data;
    assign dbg_rs2_data = rs2_data;
    assign dbg_alu_out  = alu_out;
    assign dbg_wb_data  = wb_data;
    assign dbg_reg_we   = rf_we;
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: loads a hand-assembled program into the ROM,
// preloads registers and checks PC, debug ports, registers and RAM with hand-computed values.

module tb_rv32i_single_cycle_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dbg_pc, dbg_instr, dbg_rs1_data, dbg_rs2_data;
    logic [31:0] dbg_alu_out, dbg_wb_data;
    logic        dbg_reg_we;
    int          errors;
    int          checks;
    logic [31:0] word0;

    rv32i_single_cycle_core #(
        .IMEM_DEPTH (64),
        .DMEM_DEPTH (64),
        .IMEM_FILE  ("")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dbg_pc       (dbg_pc),
        .dbg_instr    (dbg_instr),
        .dbg_rs1_data (dbg_rs1_data),
        .dbg_rs2_data (dbg_rs2_data),
        .dbg_alu_out  (dbg_alu_out),
        .dbg_wb_data  (dbg_wb_data),
        .dbg_reg_we   (dbg_reg_we)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;

        dut.imem[0]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5);            // ADD  x5,x1,x2
        dut.imem[1]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd6);            // SUB  x6,x2,x1
        dut.imem[2]  = enc_r(7'h20, 5'd3, 5'd9, 3'b101, 5'd7);            // SRA  x7,x9,x3
        dut.imem[3]  = enc_i(32'hFFFFFFFF, 5'd0, 3'b000, 5'd8, 7'h13);    // ADDI x8,x0,-1
        dut.imem[4]  = enc_r(7'h00, 5'd8, 5'd1, 3'b011, 5'd10);           // SLTU x10,x1,x8
        dut.imem[5]  = enc_r(7'h00, 5'd8, 5'd1, 3'b010, 5'd11);           // SLT  x11,x1,x8
        dut.imem[6]  = enc_s(32'd8, 5'd17, 5'd4);                         // SW   x17,8(x4)
        dut.imem[7]  = enc_i(32'd8, 5'd4, 3'b010, 5'd12, 7'h03);          // LW   x12,8(x4)
        dut.imem[8]  = enc_b(32'd8, 5'd1, 5'd1, 3'b000);                  // BEQ  x1,x1,+8
        dut.imem[9]  = enc_i(32'd1, 5'd0, 3'b000, 5'd13, 7'h13);          // ADDI x13,x0,1
        dut.imem[10] = enc_b(32'd8, 5'd1, 5'd1, 3'b001);                  // BNE  x1,x1,+8
        dut.imem[11] = enc_i(32'd5, 5'd0, 3'b000, 5'd0, 7'h13);           // ADDI x0,x0,5
        dut.imem[12] = {20'h12345, 5'd14, 7'b0110111};                    // LUI  x14,0x12345
        dut.imem[13] = enc_i(32'h0F, 5'd2, 3'b100, 5'd15, 7'h13);         // XORI x15,x2,0xF
        dut.imem[14] = enc_i(32'd4, 5'd1, 3'b001, 5'd16, 7'h13);          // SLLI x16,x1,4
        dut.imem[15] = enc_i(32'h404, 5'd8, 3'b101, 5'd18, 7'h13);        // SRAI x18,x8,4
        dut.imem[16] = enc_i(32'd28, 5'd8, 3'b101, 5'd19, 7'h13);         // SRLI x19,x8,28
        dut.imem[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd20);           // OR   x20,x1,x2
        dut.imem[18] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd21);           // AND  x21,x1,x2
        dut.imem[19] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd22);           // XOR  x22,x1,x2
        dut.imem[20] = enc_r(7'h00, 5'd3, 5'd1, 3'b001, 5'd23);           // SLL  x23,x1,x3
        dut.imem[21] = enc_r(7'h00, 5'd3, 5'd8, 3'b101, 5'd24);           // SRL  x24,x8,x3
        dut.imem[22] = enc_i(32'd0, 5'd8, 3'b010, 5'd25, 7'h13);          // SLTI x25,x8,0
        dut.imem[23] = enc_i(32'hFFFFFFFF, 5'd1, 3'b011, 5'd26, 7'h13);   // SLTIU x26,x1,-1
        dut.imem[24] = enc_i(32'h100, 5'd1, 3'b110, 5'd27, 7'h13);        // ORI  x27,x1,0x100
        dut.imem[25] = enc_i(32'hFFFFFFF0, 5'd2, 3'b111, 5'd28, 7'h13);   // ANDI x28,x2,-16
        dut.imem[26] = enc_s(32'd0, 5'd17, 5'd0);                         // SW   x17,0(x0)
        dut.imem[27] = enc_s(32'd268, 5'd2, 5'd0);                        // SW   x2,268(x0)
        dut.imem[28] = enc_i(32'd256, 5'd0, 3'b010, 5'd29, 7'h03);        // LW   x29,256(x0)
        dut.imem[29] = enc_i(32'd12, 5'd0, 3'b010, 5'd30, 7'h03);         // LW   x30,12(x0)
        dut.imem[30] = enc_b(32'd8, 5'd2, 5'd1, 3'b001);                  // BNE  x1,x2,+8
        dut.imem[31] = enc_i(32'd1, 5'd0, 3'b000, 5'd31, 7'h13);          // ADDI x31,x0,1
        dut.imem[32] = 32'h0;                                             // NOP
        dut.imem[33] = enc_j(32'hFFFFFFFC, 5'd1);                         // JAL  x1,-4
        word0 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5);

        dut.Reg_File.Registers[5]  = 32'hDEADBEEF;
        dut.Reg_File.Registers[31] = 32'h00000001;

        step();
        check_output("reset_pc", dbg_pc, 32'h0);
        check_output("reset_instr", dbg_instr, word0);
        for (int i = 1; i < 32; i++) begin
            check_output($sformatf("reset_x%0d", i), dut.Reg_File.Registers[i], 32'h0);
        end

        reset = 1'b1;
        dut.Reg_File.Registers[1]  = 32'd7;
        dut.Reg_File.Registers[2]  = 32'd19;
        dut.Reg_File.Registers[3]  = 32'd3;
        dut.Reg_File.Registers[4]  = 32'd5;
        dut.Reg_File.Registers[9]  = 32'd31;
        dut.Reg_File.Registers[17] = 32'd34;
        #1;
        check_output("add_rs1", dbg_rs1_data, 32'd7);
        check_output("add_rs2", dbg_rs2_data, 32'd19);
        check_output("add_alu", dbg_alu_out, 32'h1A);
        check_output("add_wb", dbg_wb_data, 32'h1A);
        check_output("add_we", {31'h0, dbg_reg_we}, 32'd1);

        step();
        check_output("pc_4", dbg_pc, 32'd4);
        check_output("x5", dut.Reg_File.Registers[5], 32'h1A);
        check_output("sub_we", {31'h0, dbg_reg_we}, 32'd1);
        step();
        check_output("pc_8", dbg_pc, 32'd8);
        check_output("x6", dut.Reg_File.Registers[6], 32'h0C);
        check_output("sra_we", {31'h0, dbg_reg_we}, 32'd1);
        step();
        check_output("pc_12", dbg_pc, 32'd12);
        check_output("x7", dut.Reg_File.Registers[7], 32'h03);
        step();
        check_output("x8", dut.Reg_File.Registers[8], 32'hFFFFFFFF);
        step();
        check_output("x10", dut.Reg_File.Registers[10], 32'd1);
        step();
        check_output("pc_24", dbg_pc, 32'd24);
        check_output("x11", dut.Reg_File.Registers[11], 32'd0);
        check_output("sw_we", {31'h0, dbg_reg_we}, 32'd0);
        check_output("sw_addr", dbg_alu_out, 32'd13);
        check_output("sw_data", dbg_rs2_data, 32'd34);
        step();
        check_output("ram_w3", dut.dmem[3], 32'd34);
        check_output("lw_wb", dbg_wb_data, 32'd34);
        step();
        check_output("pc_32", dbg_pc, 32'd32);
        check_output("x12", dut.Reg_File.Registers[12], 32'h22);
        check_output("beq_we", {31'h0, dbg_reg_we}, 32'd0);
        step();
        check_output("beq_taken_pc", dbg_pc, 32'd40);
        step();
        check_output("bne_not_taken_pc", dbg_pc, 32'd44);
        check_output("x13_skipped", dut.Reg_File.Registers[13], 32'd0);
        check_output("x0_write_we", {31'h0, dbg_reg_we}, 32'd0);
        step();
        check_output("pc_48", dbg_pc, 32'd48);
        check_output("x0", dut.Reg_File.Registers[0], 32'd0);

        for (int k = 12; k < 26; k++) begin
            step();
            check_output($sformatf("pc_%0d", (k + 1) * 4), dbg_pc, 32'((k + 1) * 4));
        end
        check_output("lui_x14", dut.Reg_File.Registers[14], 32'h12345000);
        check_output("xori_x15", dut.Reg_File.Registers[15], 32'h1C);
        check_output("slli_x16", dut.Reg_File.Registers[16], 32'h70);
        check_output("srai_x18", dut.Reg_File.Registers[18], 32'hFFFFFFFF);
        check_output("srli_x19", dut.Reg_File.Registers[19], 32'h0F);
        check_output("or_x20", dut.Reg_File.Registers[20], 32'h17);
        check_output("and_x21", dut.Reg_File.Registers[21], 32'h03);
        check_output("xor_x22", dut.Reg_File.Registers[22], 32'h14);
        check_output("sll_x23", dut.Reg_File.Registers[23], 32'h38);
        check_output("srl_x24", dut.Reg_File.Registers[24], 32'h1FFFFFFF);
        check_output("slti_x25", dut.Reg_File.Registers[25], 32'd1);
        check_output("sltiu_x26", dut.Reg_File.Registers[26], 32'd1);
        check_output("ori_x27", dut.Reg_File.Registers[27], 32'h107);
        check_output("andi_x28", dut.Reg_File.Registers[28], 32'h10);

        step();
        check_output("ram_w0", dut.dmem[0], 32'd34);
        check_output("sw_oob_addr", dbg_alu_out, 32'd268);
        step();
        check_output("lw_oob_wb", dbg_wb_data, 32'd0);
        step();
        check_output("lw_oob_x29", dut.Reg_File.Registers[29], 32'd0);
        step();
        check_output("x30_after_oob_sw", dut.Reg_File.Registers[30], 32'd34);
        step();
        check_output("bne_taken_pc", dbg_pc, 32'd128);
        check_output("nop_we", {31'h0, dbg_reg_we}, 32'd0);
        step();
        check_output("nop_pc", dbg_pc, 32'd132);
        check_output("x31_skipped", dut.Reg_File.Registers[31], 32'd0);
        check_output("jal_wb", dbg_wb_data, 32'd136);
        check_output("jal_we", {31'h0, dbg_reg_we}, 32'd1);
        step();
        check_output("jal_pc", dbg_pc, 32'd128);
        check_output("jal_x1", dut.Reg_File.Registers[1], 32'd136);
        step();
        step();
        check_output("jal_loop_pc", dbg_pc, 32'd128);

        reset = 1'b0;
        step();
        check_output("midreset_pc", dbg_pc, 32'd0);
        check_output("midreset_x5", dut.Reg_File.Registers[5], 32'd0);
        check_output("midreset_x1", dut.Reg_File.Registers[1], 32'd0);
        reset = 1'b1;
        step();
        check_output("rerun_pc", dbg_pc, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
